// File: rtl/mem_master.sv
// Burst memory master: moves len words between a valid/ready stream and a simple
// synchronous-write / combinational-read word memory, one word per cycle.
module mem_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_pwrite_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic last_word;
  logic wr_accept;
  logic fetch;
  logic rd_handshake;

  // Only evaluated in WRITE/READ, where len_q is known to be non-zero.
  assign last_word    = (cnt_q == (len_q - LEN_WIDTH'(1)));
  assign wr_accept    = (state_q == WRITE) && wr_valid_i;
  assign rd_handshake = rd_valid_q && rd_ready_i;
  // The output register may be refilled when empty or when it drains this edge.
  assign fetch        = (state_q == READ) && (!rd_valid_q || rd_ready_i);

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign wr_ready_o   = (state_q == WRITE);
  assign mem_pwrite_o = wr_accept;
  assign mem_data_o   = (state_q == WRITE) ? wr_data_i : '0;
  assign mem_addr_o   = base_q + ADDR_WIDTH'(cnt_q);
  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d = base_addr_i;
          len_d  = len_i;
          cnt_d  = '0;
          if (len_i == '0)  state_d = DONE;
          else if (write_i) state_d = WRITE;
          else              state_d = READ;
        end
      end
      WRITE: begin
        if (wr_accept) begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (last_word) state_d = DONE;
        end
      end
      READ: begin
        if (fetch) begin
          rd_data_d  = mem_data_i;
          rd_valid_d = 1'b1;
          cnt_d      = cnt_q + LEN_WIDTH'(1);
          if (last_word) state_d = DRAIN;
        end else if (rd_handshake) begin
          rd_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (rd_handshake) begin
          rd_valid_d = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
